// File: rtl/fu_logical_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fu_logical_pipe : AArch64 logical shifted-register unit, STAGES deep,    |
// | valid/ready at both ends. FU_LOGICAL_FLAGS_EN adds ANDS NZCV on slot 1.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fu_logical_pipe #(
  parameter int INST_ID_BITS = 6,
  parameter int PRN_BITS     = 6,
  parameter int MAX_OPERANDS = 3,
  parameter int STAGES       = 2
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   inst_valid,
  output logic                                   inst_ready,
  input  logic [INST_ID_BITS-1:0]                inst_id,
  input  logic [31:0]                            inst,
  input  logic [MAX_OPERANDS-1:0][63:0]          op,
  input  logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  out_prn,
  input  logic                                   flush,
  output logic                                   fu_out_valid,
  input  logic                                   fu_out_ready,
  output logic [INST_ID_BITS-1:0]                out_inst_id,
  output logic [MAX_OPERANDS-1:0][63:0]          out_data,
  output logic [MAX_OPERANDS-1:0]                out_data_valid,
  output logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]  res_prn,
  output logic                                   out_illegal
);

  localparam logic [4:0] c_LOGIC_CLASS = 5'b01010;

  typedef struct packed {
    logic [INST_ID_BITS-1:0]               id;
    logic                                  illegal;
    logic [MAX_OPERANDS-1:0]               dv;
    logic [MAX_OPERANDS-1:0][63:0]         data;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn;
  } payload_t;

  logic        w_sf;
  logic [1:0]  w_opc;
  logic [1:0]  w_shift;
  logic        w_n;
  logic [5:0]  w_imm6;
  logic        w_legal;
  logic [63:0] w_rm;
  logic [31:0] w_rm32;
  logic [4:0]  w_amt32;
  logic [31:0] w_sh32;
  logic [63:0] w_op2;
  logic [63:0] w_res;
  payload_t    w_in;
  logic        w_accept;
  logic [STAGES-1:0] w_free;

  logic [STAGES-1:0]            valid_q;
  payload_t [STAGES-1:0]        pay_q;

  assign w_sf    = inst[31];
  assign w_opc   = inst[30:29];
  assign w_shift = inst[23:22];
  assign w_n     = inst[21];
  assign w_imm6  = inst[15:10];
  assign w_legal = (inst[28:24] == c_LOGIC_CLASS) && (w_sf || !w_imm6[5]);
  assign w_rm    = op[1];
  assign w_rm32  = op[1][31:0];
  assign w_amt32 = w_imm6[4:0];

  always_comb begin
    w_sh32 = '0;
    unique case (w_shift)
      2'b00:   w_sh32 = w_rm32 << w_amt32;
      2'b01:   w_sh32 = w_rm32 >> w_amt32;
      2'b10:   w_sh32 = $signed(w_rm32) >>> w_amt32;
      default: w_sh32 = (w_rm32 >> w_amt32) | (w_rm32 << (6'd32 - {1'b0, w_amt32}));
    endcase
  end

  always_comb begin
    w_op2 = '0;
    if (w_sf) begin
      unique case (w_shift)
        2'b00:   w_op2 = w_rm << w_imm6;
        2'b01:   w_op2 = w_rm >> w_imm6;
        2'b10:   w_op2 = $signed(w_rm) >>> w_imm6;
        default: w_op2 = (w_rm >> w_imm6) | (w_rm << (7'd64 - {1'b0, w_imm6}));
      endcase
    end else begin
      w_op2 = {32'd0, w_sh32};
    end
    if (w_n) begin
      w_op2 = ~w_op2;
    end
    unique case (w_opc)
      2'b01:   w_res = op[0] | w_op2;
      2'b10:   w_res = op[0] ^ w_op2;
      default: w_res = op[0] & w_op2;
    endcase
    // W forms ignore the upper half of every operand and zero-extend.
    if (!w_sf) begin
      w_res[63:32] = 32'd0;
    end
  end

  always_comb begin
    w_in         = '0;
    w_in.id      = inst_id;
    w_in.prn     = out_prn;
    w_in.illegal = !w_legal;
    if (w_legal) begin
      w_in.data[0] = w_res;
      w_in.dv[0]   = 1'b1;
`ifdef FU_LOGICAL_FLAGS_EN
      if (w_opc == 2'b11) begin
        w_in.data[1] = {60'd0, (w_sf ? w_res[63] : w_res[31]), (w_res == 64'd0), 2'b00};
        w_in.dv[1]   = 1'b1;
      end
`endif
    end
  end

  // A stage is free when empty or when everything downstream of it drains.
  always_comb begin
    logic f;
    f      = fu_out_ready;
    w_free = '0;
    for (int i = STAGES - 1; i >= 0; i--) begin
      f         = !valid_q[i] || f;
      w_free[i] = f;
    end
  end

  assign inst_ready = rst && !flush && w_free[0];
  assign w_accept   = inst_valid && inst_ready;

  for (genvar s = 0; s < STAGES; s++) begin : g_stage
    logic     valid_d;
    payload_t pay_d;
    if (s == 0) begin : g_head
      assign valid_d = w_accept;
      assign pay_d   = w_in;
    end else begin : g_tail
      assign valid_d = valid_q[s-1];
      assign pay_d   = pay_q[s-1];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        valid_q[s] <= 1'b0;
        pay_q[s]   <= '0;
      end else if (flush) begin
        valid_q[s] <= 1'b0;
      end else if (w_free[s]) begin
        valid_q[s] <= valid_d;
        pay_q[s]   <= pay_d;
      end
    end
  end

  assign fu_out_valid   = valid_q[STAGES-1];
  assign out_inst_id    = pay_q[STAGES-1].id;
  assign out_data       = pay_q[STAGES-1].data;
  assign out_data_valid = pay_q[STAGES-1].dv;
  assign res_prn        = pay_q[STAGES-1].prn;
  assign out_illegal    = valid_q[STAGES-1] && pay_q[STAGES-1].illegal;

  if (MAX_OPERANDS > 2) begin : g_unused_ops
    logic w_unused_ops;
    assign w_unused_ops = ^op[MAX_OPERANDS-1:2];
  end
  logic w_unused_fields;
  assign w_unused_fields = ^{inst[20:16], inst[9:0]};

endmodule
`default_nettype wire

// File: tb/tb_fu_logical_pipe.sv
`default_nettype none
// Self-checking bench for fu_logical_pipe: directed vector table, pipeline
// corner sequences and randomized traffic against an arithmetic reference model.
module tb_fu_logical_pipe;

`ifdef FU_LOGICAL_FLAGS_EN
  localparam bit FLAGS = 1'b1;
`else
  localparam bit FLAGS = 1'b0;
`endif
  localparam int STAGES = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             inst_valid = 1'b0;
  logic             inst_ready;
  logic [5:0]       inst_id = '0;
  logic [31:0]      inst = '0;
  logic [2:0][63:0] op = '0;
  logic [2:0][5:0]  out_prn = '0;
  logic             flush = 1'b0;
  logic             fu_out_valid;
  logic             fu_out_ready = 1'b1;
  logic [5:0]       out_inst_id;
  logic [2:0][63:0] out_data;
  logic [2:0]       out_data_valid;
  logic [2:0][5:0]  res_prn;
  logic             out_illegal;

  fu_logical_pipe #(.INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .STAGES(STAGES)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_id(inst_id), .inst(inst), .op(op), .out_prn(out_prn), .flush(flush),
    .fu_out_valid(fu_out_valid), .fu_out_ready(fu_out_ready), .out_inst_id(out_inst_id),
    .out_data(out_data), .out_data_valid(out_data_valid), .res_prn(res_prn),
    .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]      id;
    bit              ill;
    logic [1:0]      dv;
    logic [63:0]     d0;
    logic [63:0]     d1;
    logic [2:0][5:0] prn;
  } exp_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] a;
    logic [63:0] b;
    bit          ill;
    logic [1:0]  dv;
    logic [63:0] d0;
    logic [63:0] d1;
  } vec_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_deliv = 0;
  exp_t q[$];

  bit              h_valid = 0;
  logic [5:0]      h_id;
  logic [2:0][63:0] h_data;
  logic [2:0]      h_dv;
  logic [2:0][5:0] h_prn;
  logic            h_ill;

  function automatic logic [31:0] enc(bit sf, logic [1:0] opc, logic [1:0] sh, bit n, logic [5:0] imm);
    return {sf, opc, 5'b01010, sh, n, 5'd0, imm, 10'd0};
  endfunction

  // Reference: shifts as multiply/divide by powers of two, rotate bit by bit.
  function automatic exp_t model(logic [31:0] i, logic [63:0] a0, logic [63:0] b0,
                                 logic [5:0] id, logic [2:0][5:0] prn);
    exp_t e;
    int w, amt;
    logic [63:0] mask, a, b, r, p, res;
    e.id = id; e.prn = prn; e.d0 = 0; e.d1 = 0; e.dv = 0;
    w    = i[31] ? 64 : 32;
    mask = i[31] ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    amt  = int'(i[15:10]);
    e.ill = !(i[28:24] == 5'b01010 && (w == 64 || amt < 32));
    if (e.ill) return e;
    a = a0 & mask; b = b0 & mask; p = 64'd1;
    repeat (amt) p = p * 64'd2;
    case (i[23:22])
      2'd0: r = (b * p) & mask;
      2'd1: r = b / p;
      2'd2: r = b[w-1] ? (~((~b & mask) / p)) & mask : b / p;
      default: begin
        r = 0;
        for (int j = 0; j < w; j++) r[j] = b[(j + amt) % w];
      end
    endcase
    if (i[21]) r = ~r & mask;
    case (i[30:29])
      2'd1: res = a | r;
      2'd2: res = a ^ r;
      default: res = a & r;
    endcase
    e.d0 = res; e.dv = 2'b01;
    if (FLAGS && i[30:29] == 2'd3) begin
      e.dv = 2'b11;
      e.d1 = {60'd0, res[w-1], (res == 64'd0), 2'b00};
    end
    return e;
  endfunction

  task automatic chk(bit ok, string name, logic [63:0] act, logic [63:0] expv);
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic cmp_out(exp_t e);
    chk(out_inst_id == e.id, "out_inst_id", 64'(out_inst_id), 64'(e.id));
    chk(out_illegal == e.ill, "out_illegal", 64'(out_illegal), 64'(e.ill));
    chk(out_data_valid == {1'b0, e.dv}, "out_data_valid", 64'(out_data_valid), 64'({1'b0, e.dv}));
    if (e.dv[0]) chk(out_data[0] == e.d0, "out_data0", out_data[0], e.d0);
    if (e.dv[1]) chk(out_data[1] == e.d1, "out_data1", out_data[1], e.d1);
    chk(res_prn == e.prn, "res_prn", 64'(res_prn), 64'(e.prn));
  endtask

  // Samples at the falling edge the handshakes that the next rising edge will complete.
  task automatic monitor();
    exp_t e;
    if (!rst) begin
      q.delete(); h_valid = 0;
      return;
    end
    if (h_valid && fu_out_valid) begin
      chk(out_inst_id == h_id && out_data == h_data && out_data_valid == h_dv &&
          res_prn == h_prn && out_illegal == h_ill, "stall_hold", 64'(out_inst_id), 64'(h_id));
    end
    if (fu_out_valid && fu_out_ready) begin
      if (q.size() == 0) begin
        chk(1'b0, "unexpected_result", 64'(out_inst_id), 64'd0);
      end else begin
        e = q.pop_front();
        cmp_out(e);
        n_deliv++;
      end
    end
    if (inst_valid && inst_ready) q.push_back(model(inst, op[0], op[1], inst_id, out_prn));
    if (flush) q.delete();
    h_valid = fu_out_valid && !fu_out_ready && !flush;
    h_id = out_inst_id; h_data = out_data; h_dv = out_data_valid; h_prn = res_prn; h_ill = out_illegal;
  endtask

  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inst();
    inst = $urandom;
    if ($urandom_range(9) != 0) inst[28:24] = 5'b01010;
    op[0] = {$urandom, $urandom};
    op[1] = {$urandom, $urandom};
    op[2] = {$urandom, $urandom};
    out_prn = 18'($urandom);
  endtask

  task automatic drain(string name);
    int k = 0;
    inst_valid = 0; fu_out_ready = 1;
    while ((q.size() != 0 || fu_out_valid) && k < 50) begin tick(); k++; end
    chk(q.size() == 0 && !fu_out_valid, name, 64'(q.size()), 64'd0);
  endtask

  vec_t tv[9];

  initial begin
    int acc, k, base;
    logic [5:0] next_id;

    tv[0] = '{enc(1, 2'd0, 2'd0, 0, 6'd4), 64'hFF00, 64'h0FF0, 0, 2'b01, 64'hFF00, 64'h0};
    tv[1] = '{enc(0, 2'd1, 2'd3, 1, 6'd8), 64'h0, 64'hFF, 0, 2'b01, 64'h0000_0000_00FF_FFFF, 64'h0};
    tv[2] = '{enc(1, 2'd3, 2'd0, 0, 6'd0), 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
              0, {FLAGS, 1'b1}, 64'h8000_0000_0000_0000, 64'h8};
    tv[3] = '{enc(1, 2'd2, 2'd2, 0, 6'd4), 64'h0, 64'h8000_0000_0000_0000, 0, 2'b01,
              64'hF800_0000_0000_0000, 64'h0};
    tv[4] = '{enc(0, 2'd0, 2'd0, 0, 6'd32), 64'h1, 64'h1, 1, 2'b00, 64'h0, 64'h0};
    tv[5] = '{32'h0000_0000, 64'h5, 64'h3, 1, 2'b00, 64'h0, 64'h0};
    tv[6] = '{enc(0, 2'd3, 2'd0, 0, 6'd0), 64'hFFFF_FFFF_0000_0000, 64'h1234, 0,
              {FLAGS, 1'b1}, 64'h0, 64'h4};
    tv[7] = '{enc(0, 2'd0, 2'd1, 0, 6'd4), 64'hFFFF_FFFF, 64'hFFFF_FFFF_F000_0000, 0, 2'b01,
              64'h0F00_0000, 64'h0};
    tv[8] = '{enc(1, 2'd0, 2'd1, 1, 6'd63), 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000,
              0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk(inst_ready == 0, "reset_inst_ready", 64'(inst_ready), 64'd0);
    chk(fu_out_valid == 0, "reset_out_valid", 64'(fu_out_valid), 64'd0);
    chk(out_illegal == 0, "reset_out_illegal", 64'(out_illegal), 64'd0);
    chk(out_data == '0, "reset_payload", out_data[0], 64'd0);
    rst = 1; inst_valid = 1; inst_id = 6'd63; rand_inst();
    #1;
    chk(inst_ready == 1, "first_edge_ready", 64'(inst_ready), 64'd1);
    tick();
    drain("drain_after_reset");

    // Directed vector table
    for (int i = 0; i < 9; i++) begin
      inst = tv[i].inst; op[0] = tv[i].a; op[1] = tv[i].b; op[2] = 64'hDEAD;
      inst_id = 6'(i + 1); out_prn = {6'(i), 6'(i + 20), 6'(i + 40)};
      inst_valid = 1; fu_out_ready = 1;
      tick();
      inst_valid = 0;
      k = 0;
      while (!fu_out_valid && k < 10) begin tick(); k++; end
      chk(k == STAGES - 1, "tv_latency", 64'(k), 64'(STAGES - 1));
      chk(out_inst_id == 6'(i + 1), "tv_id", 64'(out_inst_id), 64'(i + 1));
      chk(out_illegal == tv[i].ill, "tv_illegal", 64'(out_illegal), 64'(tv[i].ill));
      chk(out_data_valid == {1'b0, tv[i].dv}, "tv_dv", 64'(out_data_valid), 64'({1'b0, tv[i].dv}));
      if (tv[i].dv[0]) chk(out_data[0] == tv[i].d0, "tv_data0", out_data[0], tv[i].d0);
      if (tv[i].dv[1]) chk(out_data[1] == tv[i].d1, "tv_data1", out_data[1], tv[i].d1);
      tick();
    end
    drain("drain_table");

    // Back-to-back issue into a stalled consumer
    fu_out_ready = 0; acc = 0; base = n_deliv; next_id = 6'd10;
    for (int c = 0; c < 6; c++) begin
      inst_valid = 1; inst_id = next_id; rand_inst();
      #1;
      if (inst_ready) begin acc++; next_id++; end
      tick();
    end
    chk(acc == STAGES, "stall_accepts", 64'(acc), 64'(STAGES));
    inst_id = next_id;
    #1;
    chk(inst_ready == 0, "stall_ready_low", 64'(inst_ready), 64'd0);
    fu_out_ready = 1; k = 0;
    while (acc < 4 && k < 20) begin
      inst_valid = 1; inst_id = next_id; rand_inst();
      #1;
      if (inst_ready) begin acc++; next_id++; end
      tick(); k++;
    end
    drain("drain_b2b");
    chk(n_deliv - base == 4, "b2b_delivered", 64'(n_deliv - base), 64'd4);

    // Flush with two in flight
    fu_out_ready = 0; acc = 0; k = 0;
    while (acc < 2 && k < 10) begin
      inst_valid = 1; inst_id = next_id; rand_inst();
      #1;
      if (inst_ready) begin acc++; next_id++; end
      tick(); k++;
    end
    inst_valid = 0; flush = 1;
    #1;
    chk(inst_ready == 0, "flush_ready_low", 64'(inst_ready), 64'd0);
    tick();
    flush = 0;
    chk(fu_out_valid == 0, "flush_out_valid", 64'(fu_out_valid), 64'd0);
    chk(q.size() == 0, "flush_queue", 64'(q.size()), 64'd0);
    inst_valid = 1; inst_id = 6'd50; rand_inst(); fu_out_ready = 1;
    tick();
    inst_valid = 0;
    k = 0;
    while (!fu_out_valid && k < 10) begin tick(); k++; end
    chk(out_inst_id == 6'd50, "post_flush_tag", 64'(out_inst_id), 64'd50);
    drain("drain_flush");

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      inst_valid = ($urandom_range(3) != 0);
      inst_id = 6'($urandom); rand_inst();
      fu_out_ready = ($urandom_range(2) != 0);
      flush = ($urandom_range(24) == 0);
      tick();
    end
    flush = 0;
    drain("drain_random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
